cache_system_nway: RTL and testbench
====================================

CACHE_SYSTEM_NWAY -- requirements
Module: cache_system_nway

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; the word offset is log2(DATA_WIDTH/8) bits.
REQ-003 SHALL have parameter WAYS, default 4, associativity, legal values 1/2/4/8; WAYS=1 makes the cache direct-mapped.
REQ-004 SHALL have parameter SETS, default 8, power of two >= 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port read, input, 1 bit: request strobe, accepted when read=1 and ready=1.
REQ-008 SHALL have port addr, input, ADDR_WIDTH bits: request byte address, sampled on accept.
REQ-009 SHALL have port flush, input, 1 bit: invalidate all lines.
REQ-010 SHALL have port ready, output, 1 bit: equals (state==IDLE) and not flush.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port read_data, output, DATA_WIDTH bits: response word, held until the next response.
REQ-013 SHALL have port hit, output, 1 bit: response was a hit; qualified by resp_valid.
REQ-014 SHALL have port mem_req, output, 1 bit: backing-memory fetch request.
REQ-015 SHALL have port mem_addr, output, ADDR_WIDTH bits: fetch address, offset bits zeroed.
REQ-016 SHALL have port mem_ack, input, 1 bit: fetch complete, mem_rdata valid in the same cycle.
REQ-017 SHALL have port mem_rdata, input, DATA_WIDTH bits: fetched word.
REQ-018 SHALL have port hit_count, output, 16 bits: saturating count of hits.
REQ-019 SHALL have port miss_count, output, 16 bits: saturating count of misses.

Function
REQ-020 SHALL split addr as: index = addr[OFF +: log2(SETS)]; tag = all bits above index; offset bits ignored.
REQ-021 SHALL implement FSM IDLE -> LOOKUP -> (hit: IDLE | miss: MISS); MISS -> IDLE on mem_ack=1.
REQ-022 Accept at edge N SHALL register addr; at edge N+1 (LOOKUP) SHALL compare the tag against all valid ways of the set.
REQ-023 Hit SHALL assert resp_valid=1, hit=1, read_data=line data after edge N+1 (latency 2 edges from accept).
REQ-024 Miss SHALL assert mem_req=1 with registered mem_addr after edge N+1; both SHALL hold stable until mem_ack is sampled high.
REQ-025 mem_ack at edge M SHALL: write tag/data/valid into the victim way; drop mem_req; pulse resp_valid=1, hit=0, read_data=mem_rdata.
REQ-026 mem_ack outside MISS SHALL be ignored.
REQ-027 Victim SHALL be the lowest-index invalid way, else the way with age WAYS-1.
REQ-028 LRU SHALL keep a log2(WAYS)-bit age per way per set.
REQ-029 On a hit or fill to way w: ages < age[w] increment, age[w] becomes 0; ages SHALL remain a permutation of 0..WAYS-1.
REQ-030 Response SHALL increment hit_count on a hit and miss_count on a miss, each saturating at 0xFFFF.
REQ-031 flush=1 in IDLE SHALL clear all valid bits at the next edge and reset ages to way index; counters unaffected.
REQ-032 Simultaneous flush and read in IDLE: flush wins and the read is not accepted, since ready=0.
REQ-033 flush outside IDLE SHALL be ignored.
REQ-034 A new read MAY be accepted in the same cycle resp_valid is high (back-to-back).

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state=IDLE, all valid=0, ages=way index, ready=1, resp_valid=0, hit=0, read_data=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0.
REQ-036 Reset during MISS SHALL drop mem_req immediately, with no fill or response.

Structure
REQ-037 Shared package cache_pkg SHALL hold the FSM state encoding and the OFF/index/tag width localparam derivations.
REQ-038 Sub-module cache_lru_ages SHALL compute the victim and updated ages for one set.
REQ-039 Data/tag arrays SHALL be register-based (flops).

Verification
REQ-040 Bench SHALL use WAYS=4, SETS=8, memory ack 3 cycles after mem_req, mem_rdata = {addr,~addr} pattern; read trace 020,040,060,020,080,0a0,040,0c0,0e0,020 -> only access 4 hits; hit_count=1, miss_count=9.
REQ-041 Bench SHALL run the same trace with WAYS=1 and with WAYS=2 -> hit_count=0 and miss_count=10 for each.
REQ-042 Bench SHALL check hit timing: read 020 twice -> second resp_valid exactly 2 edges after accept with hit=1 and mem_req never asserted.
REQ-043 Bench SHALL flush after caching 020, then read 020 -> miss and mem_req=1; flush+read in the same cycle -> ready=0 and no response.
REQ-044 Bench SHALL assert rst_n low while mem_req=1 -> mem_req=0 without waiting for a clock edge; the next read 020 misses and hit_count=0.
REQ-045 Bench SHALL issue 0x10000 hits -> hit_count stays 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache: FSM state encoding and address-field width helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2
    } state_t;

    function automatic int off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int data_width, input int sets);
        return addr_width - off_bits(data_width) - idx_bits(sets);
    endfunction

    // A direct-mapped cache still carries a 1-bit age/way field so vectors never collapse to zero width.
    function automatic int age_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Victim selection and LRU age update for a single cache set.
module cache_lru_ages
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
)(
    input  logic [WAYS-1:0][AGE_W-1:0] i_ages,
    input  logic [WAYS-1:0]            i_valid,
    input  logic [AGE_W-1:0]           i_way,
    output logic [AGE_W-1:0]           o_victim,
    output logic [WAYS-1:0][AGE_W-1:0] o_ages
);

    logic w_found;

    // Prefer the lowest invalid way; only when the set is full fall back to the oldest way.
    always_comb begin
        w_found  = 1'b0;
        o_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!i_valid[w] && !w_found) begin
                w_found  = 1'b1;
                o_victim = AGE_W'(w);
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (i_ages[w] == AGE_W'(WAYS - 1)) begin
                    o_victim = AGE_W'(w);
                end
            end
        end
    end

    always_comb begin
        o_ages = i_ages;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == i_way) begin
                o_ages[w] = '0;
            end else if (i_ages[w] < i_ages[i_way]) begin
                o_ages[w] = i_ages[w] + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_system_nway.sv
// N-way set-associative read cache with LRU replacement, single-word lines and hit/miss counters.
//   state  | meaning
//   IDLE   | ready for a request or a flush
//   LOOKUP | tag compare on the registered address
//   MISS   | fetch outstanding, waiting for mem_ack
module cache_system_nway
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  flush,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  hit,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int OFF   = off_bits(DATA_WIDTH);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_WIDTH, DATA_WIDTH, SETS);
    localparam int AGE_W = age_bits(WAYS);

    state_t                            r_state;
    logic [ADDR_WIDTH-1:0]             r_addr;
    logic [WAYS-1:0]                   r_valid [SETS];
    logic [WAYS-1:0][AGE_W-1:0]        r_ages  [SETS];
    logic [TAG_W-1:0]                  r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]             r_data  [SETS][WAYS];
    logic                              r_resp_valid;
    logic                              r_hit;
    logic [DATA_WIDTH-1:0]             r_read_data;
    logic                              r_mem_req;
    logic [ADDR_WIDTH-1:0]             r_mem_addr;
    logic [15:0]                       r_hit_count;
    logic [15:0]                       r_miss_count;

    logic [IDX_W-1:0]                  w_idx;
    logic [TAG_W-1:0]                  w_tag;
    logic                              w_hit;
    logic [AGE_W-1:0]                  w_hit_way;
    logic [AGE_W-1:0]                  w_victim;
    logic [AGE_W-1:0]                  w_touch_way;
    logic [WAYS-1:0][AGE_W-1:0]        w_ages_upd;
    logic                              w_unused_off;

    assign w_idx        = r_addr[OFF +: IDX_W];
    assign w_tag        = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_unused_off = ^r_addr[OFF-1:0];
    assign w_touch_way  = (r_state == ST_LOOKUP) ? w_hit_way : w_victim;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_W'(w);
            end
        end
    end

    cache_lru_ages #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .i_ages   (r_ages[w_idx]),
        .i_valid  (r_valid[w_idx]),
        .i_way    (w_touch_way),
        .o_victim (w_victim),
        .o_ages   (w_ages_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            r_read_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ages[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            r_valid[s] <= '0;
                            for (int w = 0; w < WAYS; w++) begin
                                r_ages[s][w] <= AGE_W'(w);
                            end
                        end
                    end else if (read) begin
                        r_addr  <= addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid  <= 1'b1;
                        r_hit         <= 1'b1;
                        r_read_data   <= r_data[w_idx][w_hit_way];
                        r_ages[w_idx] <= w_ages_upd;
                        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        r_state    <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mem_ack) begin
                        r_valid[w_idx][w_victim] <= 1'b1;
                        r_ages[w_idx]            <= w_ages_upd;
                        r_mem_req                <= 1'b0;
                        r_resp_valid             <= 1'b1;
                        r_hit                    <= 1'b0;
                        r_read_data              <= mem_rdata;
                        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                        r_state                  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid bits alone decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (r_state == ST_MISS && mem_ack) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= mem_rdata;
        end
    end

    assign ready      = (r_state == ST_IDLE) && !flush;
    assign resp_valid = r_resp_valid;
    assign read_data  = r_read_data;
    assign hit        = r_hit;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cache_system_nway.sv
// Directed bench: three caches (4-way, direct-mapped, 2-way) on shared stimulus, one selected at a time.
module tb_cache_system_nway;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic        flush;
    logic [10:0] addr;
    int          sel;

    logic        ready      [3];
    logic        resp_valid [3];
    logic [31:0] read_data  [3];
    logic        hit        [3];
    logic        mem_req    [3];
    logic [10:0] mem_addr   [3];
    logic        mem_ack    [3];
    logic [31:0] mem_rdata  [3];
    logic [15:0] hit_count  [3];
    logic [15:0] miss_count [3];
    int          ack_cnt    [3];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NW = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        cache_system_nway #(
            .ADDR_WIDTH (11),
            .DATA_WIDTH (32),
            .WAYS       (NW),
            .SETS       (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .read       (read && (sel == g)),
            .addr       (addr),
            .flush      (flush && (sel == g)),
            .ready      (ready[g]),
            .resp_valid (resp_valid[g]),
            .read_data  (read_data[g]),
            .hit        (hit[g]),
            .mem_req    (mem_req[g]),
            .mem_addr   (mem_addr[g]),
            .mem_ack    (mem_ack[g]),
            .mem_rdata  (mem_rdata[g]),
            .hit_count  (hit_count[g]),
            .miss_count (miss_count[g])
        );
    end

    // Backing memory: ack raised on the third falling edge after mem_req is seen, held for one cycle.
    initial begin
        for (int g = 0; g < 3; g++) begin
            mem_ack[g]   = 1'b0;
            mem_rdata[g] = '0;
            ack_cnt[g]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n || mem_ack[g]) begin
                mem_ack[g] = 1'b0;
                ack_cnt[g] = 0;
            end else if (mem_req[g]) begin
                ack_cnt[g] = ack_cnt[g] + 1;
                if (ack_cnt[g] == 3) mem_ack[g] = 1'b1;
            end
            mem_rdata[g] = {10'd0, mem_addr[g], ~mem_addr[g]};
        end
    end

    function automatic logic [31:0] exp_data(input logic [10:0] a);
        logic [10:0] l;
        l = {a[10:2], 2'b00};
        return {10'd0, l, ~l};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a falling edge; lat counts rising edges from the accepting edge (=1) to the response.
    task automatic do_read(input int s, input logic [10:0] a, output logic h,
                           output logic [31:0] d, output int lat, output logic sawreq);
        int n;
        n = 0;
        while (!ready[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        sel    = s;
        addr   = a;
        read   = 1'b1;
        sawreq = 1'b0;
        @(posedge clk);
        #1;
        read = 1'b0;
        lat  = 1;
        while (!resp_valid[s] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            sawreq = sawreq | mem_req[s];
        end
        if (!resp_valid[s]) lat = 99;
        h = hit[s];
        d = read_data[s];
        @(negedge clk);
    endtask

    typedef struct {
        int          sel;
        logic [10:0] a;
        logic        exp_hit;
    } vec_t;

    vec_t        vecs  [30];
    logic [10:0] trace [10];

    initial begin
        logic        h;
        logic [31:0] d;
        int          lat;
        logic        req;
        logic        seen;
        int          n;
        int          cyc;
        logic        mid_done;

        total = 0;
        bad   = 0;
        sel   = 0;
        addr  = '0;
        read  = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;

        trace = '{11'h020, 11'h040, 11'h060, 11'h020, 11'h080,
                  11'h0a0, 11'h040, 11'h0c0, 11'h0e0, 11'h020};
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 10; i++) begin
                vecs[s*10+i].sel     = s;
                vecs[s*10+i].a       = trace[i];
                vecs[s*10+i].exp_hit = (s == 0) && (i == 3);
            end
        end

        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst%0d_ready", s), ready[s], 1);
            chk($sformatf("rst%0d_resp_valid", s), resp_valid[s], 0);
            chk($sformatf("rst%0d_hit", s), hit[s], 0);
            chk($sformatf("rst%0d_read_data", s), read_data[s], 0);
            chk($sformatf("rst%0d_mem_req", s), mem_req[s], 0);
            chk($sformatf("rst%0d_mem_addr", s), mem_addr[s], 0);
            chk($sformatf("rst%0d_hit_count", s), hit_count[s], 0);
            chk($sformatf("rst%0d_miss_count", s), miss_count[s], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            do_read(vecs[k].sel, vecs[k].a, h, d, lat, req);
            chk($sformatf("trace%0d_hit", k), h, vecs[k].exp_hit);
            chk($sformatf("trace%0d_data", k), d, exp_data(vecs[k].a));
            chk($sformatf("trace%0d_latency", k), lat, vecs[k].exp_hit ? 2 : 5);
        end
        chk("w4_hit_count", hit_count[0], 1);
        chk("w4_miss_count", miss_count[0], 9);
        chk("w1_hit_count", hit_count[1], 0);
        chk("w1_miss_count", miss_count[1], 10);
        chk("w2_hit_count", hit_count[2], 0);
        chk("w2_miss_count", miss_count[2], 10);

        // Hit timing: second read of the same line.
        do_reset();
        do_read(0, 11'h020, h, d, lat, req);
        chk("first020_hit", h, 0);
        do_read(0, 11'h020, h, d, lat, req);
        chk("second020_hit", h, 1);
        chk("second020_latency", lat, 2);
        chk("second020_no_mem_req", req, 0);
        chk("second020_data", d, exp_data(11'h020));

        // Flush alone invalidates the line.
        sel   = 0;
        flush = 1'b1;
        #1;
        chk("flush_ready_low", ready[0], 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        do_read(0, 11'h020, h, d, lat, req);
        chk("after_flush_hit", h, 0);
        chk("after_flush_mem_req", req, 1);

        // Flush and read together: flush wins, nothing is accepted.
        flush = 1'b1;
        read  = 1'b1;
        addr  = 11'h020;
        #1;
        chk("flush_read_ready_low", ready[0], 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        read  = 1'b0;
        seen  = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | resp_valid[0] | mem_req[0];
        end
        chk("flush_read_no_response", seen, 0);
        @(negedge clk);
        do_read(0, 11'h020, h, d, lat, req);
        chk("flush_read_then_miss", h, 0);
        chk("flush_seq_hit_count", hit_count[0], 1);
        chk("flush_seq_miss_count", miss_count[0], 3);

        // Reset while a fetch is outstanding.
        do_reset();
        sel  = 0;
        addr = 11'h046;
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        n    = 0;
        while (!mem_req[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("miss_mem_req_up", mem_req[0], 1);
        chk("miss_mem_addr_aligned", mem_addr[0], 11'h044);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req[0], 0);
        chk("async_rst_mem_addr", mem_addr[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, 11'h020, h, d, lat, req);
        chk("post_rst_020_hit", h, 0);
        chk("post_rst_hit_count", hit_count[0], 0);
        chk("post_rst_miss_count", miss_count[0], 1);

        // Hit counter saturation: one fill then 0x10000 back-to-back hits.
        do_reset();
        do_read(0, 11'h020, h, d, lat, req);
        sel      = 0;
        addr     = 11'h020;
        read     = 1'b1;
        n        = 0;
        cyc      = 0;
        mid_done = 1'b0;
        while (n < 65536 && cyc < 140000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (resp_valid[0] && hit[0]) n++;
            if (n == 65535 && !mid_done) begin
                mid_done = 1'b1;
                chk("sat_reaches_ffff", hit_count[0], 16'hFFFF);
            end
        end
        read = 1'b0;
        chk("sat_hits_seen", n, 65536);
        repeat (4) @(negedge clk);
        chk("sat_hit_count_held", hit_count[0], 16'hFFFF);
        chk("sat_miss_count", miss_count[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
